// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the buzzer arbiter: source indices, per-source beep
// patterns, tone half-periods and the arbiter FSM encoding.
package tamagotchi_pkg;

  localparam int NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_MIC      = 2'd0,
    SRC_FEED     = 2'd1,
    SRC_LOW_STAT = 2'd2,
    SRC_TEST     = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BEEP_ON  = 2'd1,
    ST_BEEP_OFF = 2'd2,
    ST_GUARD    = 2'd3
  } state_t;

  // Element [i] belongs to source i.
  localparam logic [NUM_SRC-1:0][2:0]  BEEP_COUNT = {3'd4, 3'd1, 3'd2, 3'd3};
  localparam logic [NUM_SRC-1:0][15:0] TONE_HALF_DEFAULT =
    {16'd12500, 16'd37500, 16'd50000, 16'd25000};

  function automatic src_t lowest_pending(input logic [NUM_SRC-1:0] p);
    src_t r;
    r = SRC_MIC;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (p[i]) r = src_t'(2'(i));
    end
    return r;
  endfunction

  function automatic logic [NUM_SRC-1:0] src_onehot(input src_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/buzzer_arbiter_ms_tick_gen.sv
// 1 ms prescaler: one-cycle tick every DIV clocks; clear restarts the count
// so that a tick period always begins at a state entry.
module ms_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q;

  // Tick must not depend on clear: clear is derived from tick via the FSM.
  assign tick = (cnt_q == W'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Arbitrates four alert sources onto one piezo: fixed-priority grant, per-source
// beep count and tone, source 0 preempts active patterns, guard gap after each.
module buzzer_arbiter
  import tamagotchi_pkg::*;
#(
  parameter int MS_DIV   = 50000,
  parameter int ON_MS    = 100,
  parameter int OFF_MS   = 100,
  parameter int GUARD_MS = 200,
  parameter logic [NUM_SRC-1:0][15:0] TONE_HALF = TONE_HALF_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic               mute,
  output logic               buzzer,
  output logic [NUM_SRC-1:0] grant,
  output logic               busy,
  output logic [NUM_SRC-1:0] done,
  output state_t             dbg_state
);

  state_t             state_q, state_d;
  src_t               src_q, src_d;
  logic [NUM_SRC-1:0] pending_q, done_q;
  logic [2:0]         beep_cnt_q;
  logic [15:0]        ms_cnt_q, ms_lim, tone_cnt_q;
  logic               tone_q, tick, clear, entry, ms_done;
  logic               preempt, load_beeps, next_beep, complete;

  ms_tick_gen #(.DIV(MS_DIV)) u_ms_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tick    (tick)
  );

  always_comb begin
    case (state_q)
      ST_BEEP_ON:  ms_lim = 16'(ON_MS - 1);
      ST_BEEP_OFF: ms_lim = 16'(OFF_MS - 1);
      default:     ms_lim = 16'(GUARD_MS - 1);
    endcase
  end

  assign ms_done = tick && (ms_cnt_q == ms_lim);

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    preempt    = 1'b0;
    load_beeps = 1'b0;
    next_beep  = 1'b0;
    complete   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          state_d    = ST_BEEP_ON;
          src_d      = lowest_pending(pending_q);
          load_beeps = 1'b1;
        end
      end
      ST_BEEP_ON, ST_BEEP_OFF: begin
        // The aborted source keeps its pending bit and restarts from beep one.
        if (pending_q[SRC_MIC] && (src_q != SRC_MIC)) begin
          preempt    = 1'b1;
          state_d    = ST_BEEP_ON;
          src_d      = SRC_MIC;
          load_beeps = 1'b1;
        end else if (ms_done) begin
          if (state_q == ST_BEEP_ON) begin
            state_d = ST_BEEP_OFF;
          end else if (beep_cnt_q == 3'd0) begin
            state_d  = ST_GUARD;
            complete = 1'b1;
          end else begin
            state_d   = ST_BEEP_ON;
            next_beep = 1'b1;
          end
        end
      end
      ST_GUARD: begin
        if (ms_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign entry = (state_d != state_q) || preempt;
  assign clear = entry || (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_MIC;
      pending_q  <= '0;
      done_q     <= '0;
      beep_cnt_q <= 3'd0;
      ms_cnt_q   <= 16'd0;
      tone_cnt_q <= 16'd0;
      tone_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      // Clearing wins over a same-cycle request from the finishing source.
      pending_q <= (pending_q | req) & ~(complete ? src_onehot(src_q) : '0);
      done_q    <= complete ? src_onehot(src_q) : '0;

      if (load_beeps) begin
        beep_cnt_q <= BEEP_COUNT[src_d] - 3'd1;
      end else if (next_beep) begin
        beep_cnt_q <= beep_cnt_q - 3'd1;
      end

      if (clear) begin
        ms_cnt_q <= 16'd0;
      end else if (tick) begin
        ms_cnt_q <= ms_cnt_q + 16'd1;
      end

      if ((state_q == ST_BEEP_ON) && !entry) begin
        if (tone_cnt_q == TONE_HALF[src_q] - 16'd1) begin
          tone_cnt_q <= 16'd0;
          tone_q     <= ~tone_q;
        end else begin
          tone_cnt_q <= tone_cnt_q + 16'd1;
        end
      end else begin
        tone_cnt_q <= 16'd0;
        tone_q     <= 1'b0;
      end
    end
  end

  // Mute only gates the pin; the tone generator keeps running.
  assign buzzer    = tone_q & ~mute;
  assign grant     = ((state_q == ST_BEEP_ON) || (state_q == ST_BEEP_OFF)) ?
                     src_onehot(src_q) : '0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Directed bench for buzzer_arbiter at scaled timing: 10 clk per ms,
// 2 ms on, 2 ms off, 3 ms guard, tone half-periods 2/4/3/1.
module tb_buzzer_arbiter;
  import tamagotchi_pkg::*;

  localparam int MS_DIV    = 10;
  localparam int ON_MS     = 2;
  localparam int OFF_MS    = 2;
  localparam int GUARD_MS  = 3;
  localparam int ON_CYC    = 20;
  localparam int OFF_CYC   = 20;
  localparam int GUARD_CYC = 30;
  localparam logic [3:0][15:0] TB_TONE = {16'd1, 16'd3, 16'd4, 16'd2};

  int half_tab [4] = '{2, 4, 3, 1};
  int beep_tab [4] = '{3, 2, 1, 4};

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       mute = 1'b0;
  logic       buzzer;
  logic [3:0] grant;
  logic       busy;
  logic [3:0] done;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;

  buzzer_arbiter #(
    .MS_DIV   (MS_DIV),
    .ON_MS    (ON_MS),
    .OFF_MS   (OFF_MS),
    .GUARD_MS (GUARD_MS),
    .TONE_HALF(TB_TONE)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .mute      (mute),
    .buzzer    (buzzer),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle request; returns on the following falling edge.
  task automatic pulse(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0;
  endtask

  // Starts on the first BEEP_ON cycle; follows n full beeps of src.
  // rep is pulsed on req once per BEEP_ON and once per BEEP_OFF.
  task automatic expect_beeps(input int src, input int n, input bit muted,
                              input logic [3:0] rep);
    logic [3:0] g;
    logic       b;
    g = 4'b0001 << src;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < ON_CYC; k++) begin
        b = muted ? 1'b0 : 1'(((k / half_tab[src]) % 2));
        checks++;
        if (grant !== g || busy !== 1'b1 || done !== 4'b0 || dbg_state !== ST_BEEP_ON) begin
          errors++;
          $display("FAIL on_ctrl src%0d beep%0d cyc%0d: grant=%b busy=%b done=%b state=%0d want grant=%b busy=1 done=0000 state=%0d",
                   src, i, k, grant, busy, done, dbg_state, g, ST_BEEP_ON);
        end
        checks++;
        if (buzzer !== b) begin
          errors++;
          $display("FAIL tone src%0d beep%0d cyc%0d: buzzer=%b want %b", src, i, k, buzzer, b);
        end
        req = (k == 5) ? rep : 4'b0;
        @(negedge clk);
      end
      for (int k = 0; k < OFF_CYC; k++) begin
        checks++;
        if (grant !== g || busy !== 1'b1 || done !== 4'b0 || buzzer !== 1'b0 ||
            dbg_state !== ST_BEEP_OFF) begin
          errors++;
          $display("FAIL off_ctrl src%0d beep%0d cyc%0d: grant=%b busy=%b done=%b buzzer=%b state=%0d want grant=%b busy=1 done=0000 buzzer=0 state=%0d",
                   src, i, k, grant, busy, done, buzzer, dbg_state, g, ST_BEEP_OFF);
        end
        req = (k == 10) ? rep : 4'b0;
        @(negedge clk);
      end
    end
    req = 4'b0;
  endtask

  // Starts on the first GUARD cycle; ends on the first IDLE cycle.
  task automatic expect_guard(input int src);
    logic [3:0] exp_done;
    for (int k = 0; k < GUARD_CYC; k++) begin
      exp_done = (k == 0) ? (4'b0001 << src) : 4'b0;
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL done src%0d guard cyc%0d: done=%b want %b", src, k, done, exp_done);
      end
      checks++;
      if (grant !== 4'b0 || busy !== 1'b1 || buzzer !== 1'b0 || dbg_state !== ST_GUARD) begin
        errors++;
        $display("FAIL guard src%0d cyc%0d: grant=%b busy=%b buzzer=%b state=%0d want grant=0000 busy=1 buzzer=0 state=%0d",
                 src, k, grant, busy, buzzer, dbg_state, ST_GUARD);
      end
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0 || done !== 4'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL idle_after_guard src%0d: busy=%b grant=%b done=%b state=%0d want busy=0 grant=0000 done=0000 state=%0d",
               src, busy, grant, done, dbg_state, ST_IDLE);
    end
  endtask

  // A granted source must not appear until one clock after its pending flag.
  task automatic check_still_idle(input string tag);
    checks++;
    if (grant !== 4'b0 || busy !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL %s pre_grant: grant=%b busy=%b state=%0d want grant=0000 busy=0 state=%0d",
               tag, grant, busy, dbg_state, ST_IDLE);
    end
  endtask

  task automatic quiet_window(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (busy !== 1'b0 || grant !== 4'b0 || done !== 4'b0 || buzzer !== 1'b0) begin
        errors++;
        $display("FAIL %s quiet cyc%0d: busy=%b grant=%b done=%b buzzer=%b want all zero",
                 tag, k, busy, grant, done, buzzer);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    req = 4'b0101;
    repeat (2) @(negedge clk);
    checks++;
    if (buzzer !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: buzzer=%b grant=%b busy=%b done=%b state=%0d want all zero",
               buzzer, grant, busy, done, dbg_state);
    end
    req = 4'b0;
    reset_n = 1'b1;
    @(negedge clk);
    quiet_window("post_reset", 5);
  endtask

  task automatic test_single();
    pulse(4'b0100);
    check_still_idle("single");
    @(negedge clk);
    expect_beeps(2, beep_tab[2], 1'b0, 4'b0);
    expect_guard(2);
    @(negedge clk);
    quiet_window("single", 10);
  endtask

  task automatic test_simultaneous();
    pulse(4'b1010);
    check_still_idle("simul");
    @(negedge clk);
    expect_beeps(1, beep_tab[1], 1'b0, 4'b0);
    expect_guard(1);
    @(negedge clk);
    expect_beeps(3, beep_tab[3], 1'b0, 4'b0);
    expect_guard(3);
    @(negedge clk);
    quiet_window("simul", 5);
  endtask

  task automatic test_preempt();
    pulse(4'b1000);
    check_still_idle("preempt");
    @(negedge clk);
    expect_beeps(3, 1, 1'b0, 4'b0);
    repeat (2) @(negedge clk);
    pulse(4'b0001);
    checks++;
    if (grant !== 4'b1000 || dbg_state !== ST_BEEP_ON) begin
      errors++;
      $display("FAIL preempt_before: grant=%b state=%0d want grant=1000 state=%0d",
               grant, dbg_state, ST_BEEP_ON);
    end
    @(negedge clk);
    expect_beeps(0, beep_tab[0], 1'b0, 4'b0);
    expect_guard(0);
    @(negedge clk);
    expect_beeps(3, beep_tab[3], 1'b0, 4'b0);
    expect_guard(3);
    @(negedge clk);
    quiet_window("preempt", 5);
  endtask

  task automatic test_mute();
    mute = 1'b1;
    pulse(4'b0001);
    check_still_idle("mute");
    @(negedge clk);
    expect_beeps(0, beep_tab[0], 1'b1, 4'b0);
    expect_guard(0);
    mute = 1'b0;
    @(negedge clk);
    quiet_window("mute", 5);
  endtask

  task automatic test_reset_mid();
    pulse(4'b0010);
    @(negedge clk);
    repeat (3) @(negedge clk);
    pulse(4'b0100);
    checks++;
    if (grant !== 4'b0010 || buzzer !== 1'b1) begin
      errors++;
      $display("FAIL mid_before_reset: grant=%b buzzer=%b want grant=0010 buzzer=1", grant, buzzer);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (buzzer !== 1'b0 || grant !== 4'b0 || busy !== 1'b0 || done !== 4'b0 ||
        dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset: buzzer=%b grant=%b busy=%b done=%b state=%0d want all zero",
               buzzer, grant, busy, done, dbg_state);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    quiet_window("reset_mid", 60);
    pulse(4'b0100);
    check_still_idle("reset_mid");
    @(negedge clk);
    expect_beeps(2, beep_tab[2], 1'b0, 4'b0);
    expect_guard(2);
    @(negedge clk);
  endtask

  task automatic test_repeat_absorb();
    pulse(4'b0010);
    check_still_idle("repeat");
    @(negedge clk);
    expect_beeps(1, beep_tab[1], 1'b0, 4'b0010);
    expect_guard(1);
    @(negedge clk);
    quiet_window("repeat", 50);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_mute();
    test_reset_mid();
    test_repeat_absorb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter.md
BUZZER_ARBITER -- requirements
Module: buzzer_arbiter

Interface
REQ-001 Parameter MS_DIV, default 50000, SHALL set the number of clk cycles per 1 ms tick.
REQ-002 Parameter ON_MS, default 100, SHALL set the beep-on duration in ms.
REQ-003 Parameter OFF_MS, default 100, SHALL set the inter-beep silence in ms.
REQ-004 Parameter GUARD_MS, default 200, SHALL set the silence after each completed request in ms.
REQ-005 clk  input  1  system clock (50 MHz); reset_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-006 req  input  4  one-cycle request pulses; bit 0 = mic alarm, bit 1 = feed, bit 2 = low-stat alert, bit 3 = test.
REQ-007 mute  input  1  level; while high, buzzer SHALL be held low and timing SHALL continue.
REQ-008 buzzer  output  1  square-wave tone to the piezo.
REQ-009 grant  output  4  one-hot; identifies the source being served, all-zero otherwise.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  4  one-cycle pulse on the bit of the source whose pattern completed.

Function
REQ-012 Each req bit SHALL set a pending flag on the cycle it is seen; repeated pulses while pending SHALL NOT queue extra services.
REQ-013 From IDLE with any pending flag set, the arbiter SHALL grant the lowest-index pending source on the next clk and enter BEEP_ON.
REQ-014 States SHALL be IDLE, BEEP_ON, BEEP_OFF, GUARD.
REQ-015 Transitions: BEEP_ON -> BEEP_OFF after ON_MS ticks; BEEP_OFF -> BEEP_ON if beeps remain, otherwise -> GUARD; GUARD -> IDLE after GUARD_MS ticks.
REQ-016 Beep count per source SHALL be 3, 2, 1, 4 for sources 0..3.
REQ-017 In BEEP_ON, buzzer SHALL toggle every TONE_HALF[src] clk cycles (src 0..3: 25000, 50000, 37500, 12500); it SHALL be low in all other states.
REQ-018 The pending flag of the granted source SHALL clear, and done[src] SHALL pulse, on the cycle BEEP_OFF exits to GUARD after the last beep.
REQ-019 grant SHALL stay asserted through BEEP_ON and BEEP_OFF and SHALL drop to zero on entry to GUARD.
REQ-020 Preemption: a req[0] pulse while a source 1..3 is in BEEP_ON or BEEP_OFF SHALL abort that pattern on the next clk and restart in BEEP_ON granting source 0. The aborted source SHALL stay pending and restart from its first beep later.
REQ-021 A req for the source currently being served SHALL be absorbed; it SHALL NOT cause a second service.
REQ-022 The ms tick counter SHALL restart at zero on every state entry, so each duration is exactly N ticks ±1 clk.
REQ-023 The beep counter SHALL be 3 bits wide and SHALL never wrap; the last-beep decision SHALL use the count equal to zero.
REQ-024 GUARD SHALL NOT be preempted; pending requests wait for IDLE.
REQ-025 On simultaneous pulses, all bits SHALL be latched and then served in index order, one per IDLE visit.

Reset
REQ-026 On reset_n low, asynchronously: state = IDLE, pending = 0, counters = 0, buzzer = 0, grant = 0, busy = 0, done = 0.
REQ-027 Reset mid-pattern SHALL discard all pending requests; the first req after reset_n rises SHALL be served normally.

Structure
REQ-028 Source indices, beep counts, TONE_HALF values and state encodings SHALL live in a shared package, tamagotchi_pkg.
REQ-029 The 1 ms prescaler SHALL be a sub-module, ms_tick_gen (clk, reset_n, clear, tick), instantiated once.

Verification (MS_DIV=10, ON_MS=2, OFF_MS=2, GUARD_MS=3, TONE_HALF scaled to 2/4/3/1)
REQ-030 Single req[2] -> grant=0100, exactly 1 beep of 20 cycles toggling every 3 clks, done=0100 after 40 cycles, busy low 30 cycles later.
REQ-031 req=1010 in the same cycle -> source 1 served with 2 beeps, then GUARD, then source 3 served with 4 beeps; done pulses in order 0010, then 1000.
REQ-032 req[3] in its 2nd beep, then req[0] -> grant switches to 0001 next clk; after source 0's 3 beeps and GUARD, source 3 restarts with the full 4 beeps.
REQ-033 mute high throughout a req[0] service -> buzzer constantly 0 while grant, done and all durations match the unmuted run.
REQ-034 reset_n low during source 1's BEEP_ON with req[2] pending -> all outputs 0 immediately; no service occurs after release until a new req.
REQ-035 Repeated req[1] pulses during its own service -> exactly one done[1] pulse and no second service.
